uart_boot_loader: RTL and testbench

//   UART byte receiver plus program loader that sits between the board uart_rx pin and the CPU

---
 rtl/uart_boot_loader.sv | 178 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// 8N1 UART receiver feeding a program loader that packs bytes little-endian into 32-bit
// words and writes them to sequential instruction-memory addresses while load_en is high.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line idle, waiting for a 1->0 edge on the synced line
// S_START | half a bit into the start bit, confirming it is still low
// S_DATA  | sampling 8 data bits LSB first, one per bit time
// S_STOP  | sampling the stop bit, then emitting rx_valid or frame_err
module uart_boot_loader #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int UART_BPS     = 115_200,
    parameter int ADDR_WIDTH   = 10,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    input  logic                  load_en,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic [ADDR_WIDTH-1:0] load_words
);

    localparam int CYCLE    = CLK_FREQ / UART_BPS;
    localparam int CNT_W    = $clog2(CYCLE);
    localparam int TMO_CLKS = TIMEOUT_BITS * CYCLE;
    localparam int TMO_W    = $clog2(TMO_CLKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLE / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CLKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic                   rx_s1;
    logic                   rx_s2;
    logic                   rx_prev;

    logic                   load_en_d;
    logic                   load_rise;
    logic [1:0]             byte_idx;
    logic [23:0]            word;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [TMO_W-1:0]       tmo_cnt;

    // rx_prev trails the synchroniser output by one cycle for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        cnt   <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s2;
                        if (bit_idx == 3'd7)
                            state <= S_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        if (rx_s2) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign load_rise  = load_en & ~load_en_d;
    assign load_words = wr_addr;

    // Word count and next write address always move together, so one register serves both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_en_d <= 1'b0;
            byte_idx  <= '0;
            word      <= '0;
            wr_addr   <= '0;
            tmo_cnt   <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
        end else begin
            load_en_d <= load_en;
            imem_we   <= 1'b0;

            if (rx_valid)
                tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;

            if (load_rise) begin
                wr_addr <= '0;
                if (rx_valid) begin
                    word[7:0] <= rx_data;
                    byte_idx  <= 2'd1;
                end else begin
                    byte_idx <= '0;
                end
            end else if (!load_en) begin
                byte_idx <= '0;
            end else if (rx_valid) begin
                byte_idx <= byte_idx + 1'b1;
                case (byte_idx)
                    2'd0: word[7:0]   <= rx_data;
                    2'd1: word[15:8]  <= rx_data;
                    2'd2: word[23:16] <= rx_data;
                    default: begin
                        imem_we   <= 1'b1;
                        imem_addr <= wr_addr;
                        imem_data <= {rx_data, word};
                        wr_addr   <= wr_addr + 1'b1;
                    end
                endcase
            end else if (byte_idx != '0 && tmo_cnt == '0) begin
                byte_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader at CYCLE=5: table-driven byte vectors plus
// hand-written sequences for glitch, timeout, load_en restart and mid-frame reset.
module tb_uart_boot_loader;

    localparam int CYC = 5;
    localparam int AW  = 10;

    logic          clk;
    logic          rst_n;
    logic          uart_rx;
    logic          load_en;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic [AW-1:0] load_words;

    uart_boot_loader #(
        .CLK_FREQ    (50_000_000),
        .UART_BPS    (10_000_000),
        .ADDR_WIDTH  (AW),
        .TIMEOUT_BITS(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .load_en    (load_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .load_words (load_words)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_rx;
    } byte_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_vec_t;

    byte_vec_t     vecs[13];
    wr_vec_t       wrs[3];
    logic [7:0]    rxq[$];
    logic [AW-1:0] waq[$];
    logic [31:0]   wdq[$];
    int            fe_cnt = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (imem_we) begin
            waq.push_back(imem_addr);
            wdq.push_back(imem_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CYC) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CYC) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    initial begin
        int rb;
        int fb;
        int wb;
        logic [7:0] seq[4];

        vecs[0]  = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[1]  = '{8'h1f, 1'b1, 1, 0, 8'h1f};
        vecs[2]  = '{8'h01, 1'b1, 1, 0, 8'h01};
        vecs[3]  = '{8'h3e, 1'b1, 1, 0, 8'h3e};
        vecs[4]  = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[5]  = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[6]  = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[7]  = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[8]  = '{8'h13, 1'b1, 1, 0, 8'h13};
        vecs[9]  = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[10] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[11] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[12] = '{8'ha5, 1'b0, 0, 1, 8'h00};
        wrs[0]   = '{10'd0, 32'h3e01_1f00};
        wrs[1]   = '{10'd1, 32'h0000_0000};
        wrs[2]   = '{10'd2, 32'h0000_0013};

        rst_n   = 1'b0;
        uart_rx = 1'b1;
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_data",    {24'h0, rx_data}, 32'h0);
        check("reset_pulses",     {29'h0, rx_valid, frame_err, imem_we}, 32'h0);
        check("reset_imem_addr",  {22'h0, imem_addr}, 32'h0);
        check("reset_imem_data",  imem_data, 32'h0);
        check("reset_load_words", {22'h0, load_words}, 32'h0);

        load_en = 1'b1;
        rst_n   = 1'b1;
        repeat (5) @(negedge clk);

        // Tests 1-3: twelve good bytes, then one frame with its stop bit held low
        wb = waq.size();
        for (int v = 0; v < 13; v++) begin
            rb = rxq.size();
            fb = fe_cnt;
            send_byte(vecs[v].data, vecs[v].stop);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_rx_valid_cnt", v), rxq.size() - rb, vecs[v].exp_valid);
            check($sformatf("vec%0d_frame_err_cnt", v), fe_cnt - fb, vecs[v].exp_ferr);
            if (rxq.size() > rb)
                check($sformatf("vec%0d_rx_byte", v), {24'h0, rxq[rb]}, {24'h0, vecs[v].data});
            check($sformatf("vec%0d_rx_data_out", v), {24'h0, rx_data}, {24'h0, vecs[v].exp_rx});
        end
        check("t12_write_cnt", waq.size() - wb, 3);
        for (int w = 0; w < 3; w++) begin
            if (waq.size() > wb + w) begin
                check($sformatf("t12_wr%0d_addr", w), {22'h0, waq[wb+w]}, {22'h0, wrs[w].addr});
                check($sformatf("t12_wr%0d_data", w), wdq[wb+w], wrs[w].data);
            end
        end
        check("t12_load_words", {22'h0, load_words}, 32'd3);

        // Test 4: one-clock (0.2-bit) glitch must be rejected silently
        rb = rxq.size();
        fb = fe_cnt;
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_rx_valid_cnt", rxq.size() - rb, 0);
        check("glitch_frame_err_cnt", fe_cnt - fb, 0);

        // Test 5: partial word dropped by idle timeout, next full word lands at address 3
        wb = waq.size();
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        repeat (200) @(negedge clk);
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send_byte(seq[i], 1'b1);
        repeat (3) @(negedge clk);
        check("tmo_write_cnt", waq.size() - wb, 1);
        if (waq.size() > wb) begin
            check("tmo_wr_addr", {22'h0, waq[wb]}, 32'd3);
            check("tmo_wr_data", wdq[wb], 32'h4433_2211);
        end
        check("tmo_load_words", {22'h0, load_words}, 32'd4);

        // Test 6a: bytes with load_en low are exported but never written
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        rb = rxq.size();
        wb = waq.size();
        send_byte(8'h55, 1'b1);
        repeat (3) @(negedge clk);
        check("noload_rx_valid_cnt", rxq.size() - rb, 1);
        check("noload_rx_data", {24'h0, rx_data}, 32'h55);
        check("noload_write_cnt", waq.size() - wb, 0);

        // Test 6b: load_en rise restarts at address 0
        load_en = 1'b1;
        repeat (2) @(negedge clk);
        check("restart_load_words", {22'h0, load_words}, 32'd0);
        wb = waq.size();
        seq = '{8'hde, 8'had, 8'hbe, 8'hef};
        for (int i = 0; i < 4; i++) send_byte(seq[i], 1'b1);
        repeat (3) @(negedge clk);
        check("restart_write_cnt", waq.size() - wb, 1);
        if (waq.size() > wb) begin
            check("restart_wr_addr", {22'h0, waq[wb]}, 32'd0);
            check("restart_wr_data", wdq[wb], 32'hefbe_adde);
        end
        check("restart_load_words_1", {22'h0, load_words}, 32'd1);

        // Test 6c: reset in the middle of a frame
        rb = rxq.size();
        fb = fe_cnt;
        uart_rx = 1'b0;
        repeat (3 * CYC) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rx_data",    {24'h0, rx_data}, 32'h0);
        check("midrst_pulses",     {29'h0, rx_valid, frame_err, imem_we}, 32'h0);
        check("midrst_imem_addr",  {22'h0, imem_addr}, 32'h0);
        check("midrst_imem_data",  imem_data, 32'h0);
        check("midrst_load_words", {22'h0, load_words}, 32'h0);
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_pulse", (rxq.size() - rb) + (fe_cnt - fb), 0);
        rb = rxq.size();
        send_byte(8'h5a, 1'b1);
        repeat (3) @(negedge clk);
        check("postrst_rx_valid_cnt", rxq.size() - rb, 1);
        if (rxq.size() > rb)
            check("postrst_rx_byte", {24'h0, rxq[rb]}, 32'h5a);
        check("postrst_rx_data", {24'h0, rx_data}, 32'h5a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
